// File: rtl/fir_ctrl_if.sv
// Command, sample, coefficient, shift and result signals of the FIR sequencer.
// slave is the sequencer side; master is the pin/FIR-core side that drives commands, samples and y_in.
interface fir_ctrl_if #(
  parameter int SIZE      = 8,
  parameter int NUM_COEFF = 4
);
  localparam int IW = $clog2(NUM_COEFF);

  logic [7:0]      cmd_in;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] smp_in;
  logic            smp_valid;
  logic            smp_ready;
  logic [SIZE-1:0] coeff_data;
  logic [IW-1:0]   coeff_sel;
  logic            coeff_we;
  logic            shift_en;
  logic [SIZE-1:0] shift_data;
  logic [SIZE-1:0] y_in;
  logic [SIZE-1:0] y_out;
  logic            y_valid;
  logic            busy;

  modport slave (
    input  cmd_in, cmd_valid, smp_in, smp_valid, y_in,
    output cmd_ready, smp_ready, coeff_data, coeff_sel, coeff_we,
           shift_en, shift_data, y_out, y_valid, busy
  );

  modport master (
    output cmd_in, cmd_valid, smp_in, smp_valid, y_in,
    input  cmd_ready, smp_ready, coeff_data, coeff_sel, coeff_we,
           shift_en, shift_data, y_out, y_valid, busy
  );
endinterface

// File: rtl/fir_ctrl.sv
// Byte-command sequencer for the FIR coefficient bank, delay line and result strobe; writes/shifts one cycle
// after acceptance, y_valid LATENCY+1 later; ready is state-only. FIR_CTRL_WARMUP_EN hides warm-up results.
module fir_ctrl #(
  parameter int SIZE      = 8,
  parameter int NUM_COEFF = 4,
  parameter int LATENCY   = 1
) (
  input logic       clk,
  input logic       rst_n,
  fir_ctrl_if.slave bus
);
  localparam int            IW        = $clog2(NUM_COEFF);
  localparam logic [IW-1:0] LAST      = IW'(NUM_COEFF - 1);
  localparam logic [7:0]    CMD_LOAD  = 8'h01;
  localparam logic [7:0]    CMD_START = 8'h02;
  localparam logic [7:0]    CMD_STOP  = 8'h03;
  localparam logic [7:0]    CMD_FLUSH = 8'h04;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            w_cmd_ready, w_smp_ready, w_cmd_acc, w_smp_acc;
  logic            w_coeff_we, w_shift_en;
  logic [SIZE-1:0] w_shift_data;
  logic            r_coeff_we, r_shift_en, r_y_valid;
  logic [IW-1:0]   r_coeff_sel;
  logic [SIZE-1:0] r_coeff_data, r_shift_data, r_y_out;
  logic [LATENCY-1:0] r_pipe;
  logic            w_res, w_res_vld;

  assign w_cmd_ready = (r_state != FLUSH);
  assign w_smp_ready = (r_state == RUN);
  assign w_cmd_acc   = bus.cmd_valid & w_cmd_ready;
  assign w_smp_acc   = bus.smp_valid & w_smp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // The index doubles as the LOAD coefficient pointer and the FLUSH cycle counter.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_cmd_acc) begin
          case (bus.cmd_in)
            CMD_LOAD:  begin w_state_nxt = LOAD;  w_idx_nxt = '0; end
            CMD_START: w_state_nxt = RUN;
            CMD_FLUSH: begin w_state_nxt = FLUSH; w_idx_nxt = '0; end
            default:   ;
          endcase
        end
      end
      LOAD: begin
        if (w_cmd_acc) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST) w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_cmd_acc && bus.cmd_in == CMD_STOP) w_state_nxt = IDLE;
      end
      FLUSH: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The first flush shift is launched from IDLE so the zero shifts land in T+1 .. T+NUM_COEFF.
  always_comb begin
    w_coeff_we   = 1'b0;
    w_shift_en   = 1'b0;
    w_shift_data = '0;
    case (r_state)
      IDLE:  w_shift_en = w_cmd_acc && (bus.cmd_in == CMD_FLUSH);
      LOAD:  w_coeff_we = w_cmd_acc;
      RUN: begin
        w_shift_en   = w_smp_acc;
        w_shift_data = bus.smp_in;
      end
      FLUSH: w_shift_en = (r_idx != LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coeff_we   <= 1'b0;
      r_shift_en   <= 1'b0;
      r_y_valid    <= 1'b0;
      r_coeff_sel  <= '0;
      r_coeff_data <= '0;
      r_shift_data <= '0;
      r_y_out      <= '0;
    end else begin
      r_coeff_we <= w_coeff_we;
      r_shift_en <= w_shift_en;
      r_y_valid  <= w_res_vld;
      if (w_coeff_we) begin
        r_coeff_sel  <= r_idx;
        r_coeff_data <= SIZE'(bus.cmd_in);
      end
      if (w_shift_en) r_shift_data <= w_shift_data;
      if (w_res)      r_y_out      <= bus.y_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= r_shift_en;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_res = r_pipe[LATENCY-1];

`ifdef FIR_CTRL_WARMUP_EN
  logic          w_start, w_flush_done;
  logic [IW-1:0] r_warm;

  assign w_start      = (r_state == IDLE) && w_cmd_acc && (bus.cmd_in == CMD_START);
  assign w_flush_done = (r_state == FLUSH) && (r_idx == LAST);

  // Saturates once the delay line holds only post-START samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_warm <= '0;
    else if (w_start || w_flush_done)  r_warm <= '0;
    else if (w_res && r_warm != LAST)  r_warm <= r_warm + 1'b1;
  end

  assign w_res_vld = w_res && (r_warm == LAST);
`else
  assign w_res_vld = w_res;
`endif

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.smp_ready  = w_smp_ready;
  assign bus.coeff_we   = r_coeff_we;
  assign bus.coeff_sel  = r_coeff_sel;
  assign bus.coeff_data = r_coeff_data;
  assign bus.shift_en   = r_shift_en;
  assign bus.shift_data = r_shift_data;
  assign bus.y_out      = r_y_out;
  assign bus.y_valid    = r_y_valid;
  assign bus.busy       = (r_state != IDLE) || r_shift_en || (|r_pipe) || r_y_valid;
endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Command-driven sequencer for the FIR datapath: the coefficient register bank, the sample shift register and the combinational FIR core. It loads coefficients from a byte command stream, gates sample shifts with a valid/ready handshake, and flushes the delay line. It also re-times the FIR result into a one-cycle `y_valid` strobe. It sits between the chip-level pins and the FIR instance, replacing direct pin wiring of the shift/write enables.

## Interface
- `SIZE`, 8: sample/coefficient width in bits.
- `NUM_COEFF`, 4: number of taps and shift-register depth; must be a power of two, ≥ 2.
- `LATENCY`, 1: cycles from a `shift_en` cycle to the cycle in which `y_in` is sampled; ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_in` in 8: command or coefficient byte.
- `cmd_valid` in 1: `cmd_in` valid.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `smp_in` in SIZE: input sample.
- `smp_valid` in 1: sample valid.
- `smp_ready` out 1: sample accepted when `smp_valid & smp_ready`.
- `coeff_data` out SIZE: coefficient to write; `cmd_in` zero-extended or truncated to SIZE.
- `coeff_sel` out $clog2(NUM_COEFF): coefficient index.
- `coeff_we` out 1: coefficient write strobe.
- `shift_en` out 1: shift-register advance strobe.
- `shift_data` out SIZE: value shifted in.
- `y_in` in SIZE: FIR core output.
- `y_out` out SIZE: captured result.
- `y_valid` out 1: one-cycle result strobe.
- `busy` out 1: state ≠ IDLE or result pipeline non-empty.

## Operation
- State machine states: IDLE, LOAD, RUN, FLUSH. Reset state is IDLE.
- Command bytes, honoured in IDLE:
  - 0x01 LOAD: go to LOAD; clear the index counter.
  - 0x02 START: go to RUN.
  - 0x04 FLUSH: go to FLUSH; clear the index counter.
  - Any other byte is consumed and ignored.
- IDLE outputs: `cmd_ready`=1, `smp_ready`=0.
- LOAD:
  - `cmd_ready`=1.
  - Every accepted byte is coefficient data; no escape, so 0x03 is data too.
  - Each accepted byte produces, next cycle, `coeff_we`=1 with `coeff_sel`=index and `coeff_data`=byte.
  - The index then increments. The NUM_COEFF-th byte returns the FSM to IDLE.
- RUN:
  - `cmd_ready`=1 and `smp_ready`=1.
  - An accepted sample produces, next cycle, `shift_en`=1 with `shift_data`=sample.
  - Command 0x03 STOP returns to IDLE. All other bytes are consumed and ignored.
- FLUSH:
  - `cmd_ready`=0 and `smp_ready`=0.
  - Issues `shift_en`=1 with `shift_data`=0 for NUM_COEFF consecutive cycles, then returns to IDLE.
- Result pipeline:
  - Each `shift_en` cycle enters a LATENCY-deep valid pipe.
  - When the pipe output is set, `y_in` is registered into `y_out` and `y_valid` pulses the following cycle.
  - FLUSH shifts also produce results.
- Simultaneous events:
  - STOP and a sample accepted in the same RUN cycle: the sample's shift and result are still issued; the FSM enters IDLE.
  - Leaving RUN or FLUSH never cancels in-flight results. `busy` stays high until the last `y_valid`.
- Reset mid-operation, asynchronous:
  - State → IDLE; index and pipe cleared.
  - `coeff_we`, `shift_en`, `y_valid`, `coeff_sel`, `coeff_data`, `shift_data`, `y_out` → 0.
  - Coefficient registers and shift register are reset by their own blocks.

## Timing
- Reset values: `cmd_ready`=1 (IDLE), `smp_ready`=0, `busy`=0; all registered outputs 0.
- `cmd_ready`, `smp_ready` and `busy` are combinational from state and pipe occupancy only, never from `*_valid`.
- Sample accepted at the edge ending cycle T:
  - `shift_en` high in cycle T+1.
  - `y_in` sampled at the edge ending cycle T+1+LATENCY.
  - `y_valid` high in cycle T+2+LATENCY.
- Throughput: one sample per cycle in RUN, with no bubbles.
- Coefficient byte accepted in cycle T: `coeff_we` high in cycle T+1.
- FLUSH command accepted in cycle T: `shift_en` high in cycles T+1 … T+NUM_COEFF; `cmd_ready` returns to 1 in cycle T+NUM_COEFF+1.

## Configuration
- `FIR_CTRL_WARMUP_EN` defined:
  - A warm-up counter is cleared on START and on FLUSH completion.
  - `y_valid` is suppressed for the first NUM_COEFF−1 results after START, i.e. until the delay line holds only post-START samples.
  - `y_out` still updates during warm-up. The counter saturates.
- `FIR_CTRL_WARMUP_EN` undefined: every shift produces a `y_valid` and no warm-up counter exists.

## Test plan
- Reset check: assert `rst_n`=0 mid-LOAD, after 2 bytes. Expect all strobes 0, FSM in IDLE. A following 0x01 plus 4 bytes 0x05,0x06,0x07,0x08 gives `coeff_we` with `coeff_sel` 0,1,2,3 and those values.
- LOAD data: send 0x01, 0x03, 0x02, 0x04, 0x01. All four data bytes are written as coefficients, not decoded as commands. Expect IDLE after the 4th; `smp_ready` stays 0.
- Streaming: START, then smp_valid held for samples 1..8 back-to-back with `y_in` looped from a model FIR. Expect 8 `shift_en` pulses in consecutive cycles and 8 `y_valid` pulses, the first at cycle T+2+LATENCY. With `FIR_CTRL_WARMUP_EN`, expect only 5 pulses.
- STOP collision: STOP and sample 0x7F accepted in the same cycle. Expect `shift_en` with 0x7F next cycle, the matching `y_valid`, state IDLE, and `busy` falling only after that `y_valid`.
- FLUSH: expect exactly 4 `shift_en` pulses with `shift_data`=0 and `cmd_ready`=0 throughout. A sample offered during FLUSH is not accepted (`smp_ready`=0).
